// File: rtl/vga_term_ctrl.sv
// Terminal control stage: decodes a byte stream, tracks the cursor and drives Wishbone writes into vga_char.
// Each bus write holds cyc until ack (or timeout) and then idles one cycle; char_ready_o is high only in IDLE.
module vga_term_ctrl #(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] char_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    output logic       wb_cyc_o,
    output logic       wb_we_o,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    input  logic       wb_ack_i,
    output logic [6:0] col_o,
    output logic [4:0] row_o,
    output logic       err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_WR_X, S_WR_Y, S_WR_G,
        S_ADVANCE, S_LINEFEED, S_WR_SCR, S_WR_CLR
    } state_t;

    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state, state_n;
    logic       gap, gap_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] ch, ch_n;
    logic [6:0] col, col_n;
    logic [4:0] row, row_n;
    logic       err, err_n;
    logic       ready, ready_n;

    logic       is_wr;
    logic       cyc;
    logic [2:0] waddr;
    logic [7:0] wdat;
    state_t     wr_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            gap   <= 1'b0;
            cnt   <= 8'd0;
            ch    <= 8'd0;
            col   <= 7'd0;
            row   <= 5'd0;
            err   <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            gap   <= gap_n;
            cnt   <= cnt_n;
            ch    <= ch_n;
            col   <= col_n;
            row   <= row_n;
            err   <= err_n;
            ready <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap;
        cnt_n   = cnt;
        ch_n    = ch;
        col_n   = col;
        row_n   = row;
        err_n   = err;
        is_wr   = 1'b0;
        cyc     = 1'b0;
        waddr   = 3'd0;
        wdat    = 8'd0;
        wr_next = S_IDLE;

        case (state)
            S_IDLE: begin
                if (char_valid_i && ready) begin
                    ch_n    = char_i;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ch >= 8'h20 && ch <= 8'h7E) begin
                    state_n = S_WR_X;
                end else begin
                    state_n = S_IDLE;
                    case (ch)
                        8'h0D: col_n = 7'd0;
                        8'h0A: state_n = S_LINEFEED;
                        8'h08: if (col != 7'd0) col_n = col - 7'd1;
                        8'h0C: state_n = S_WR_CLR;
                        default: ;
                    endcase
                end
            end
            S_WR_X: begin
                is_wr = 1'b1; waddr = 3'd1; wdat = {1'b0, col}; wr_next = S_WR_Y;
            end
            S_WR_Y: begin
                is_wr = 1'b1; waddr = 3'd2; wdat = {3'b000, row}; wr_next = S_WR_G;
            end
            S_WR_G: begin
                is_wr = 1'b1; waddr = 3'd0; wdat = ch; wr_next = S_ADVANCE;
            end
            S_WR_SCR: begin
                is_wr = 1'b1; waddr = 3'd3; wdat = 8'h01; wr_next = S_IDLE;
            end
            S_WR_CLR: begin
                is_wr = 1'b1; waddr = 3'd3; wdat = 8'h80; wr_next = S_IDLE;
            end
            S_ADVANCE: begin
                if (col < COL_MAX) begin
                    col_n   = col + 7'd1;
                    state_n = S_IDLE;
                end else begin
                    col_n   = 7'd0;
                    state_n = S_LINEFEED;
                end
            end
            S_LINEFEED: begin
                if (row < ROW_MAX) begin
                    row_n   = row + 5'd1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WR_SCR;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Write states share one engine: a cyc phase (until ack/timeout) then a one-cycle gap.
        if (is_wr) begin
            if (!gap) begin
                cyc = 1'b1;
                if (wb_ack_i) begin
                    gap_n = 1'b1;
                    cnt_n = 8'd0;
                    if (state == S_WR_CLR) begin
                        col_n = 7'd0;
                        row_n = 5'd0;
                    end
                end else if (cnt == TO_LAST) begin
                    err_n   = 1'b1;
                    cnt_n   = 8'd0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end else begin
                gap_n   = 1'b0;
                state_n = wr_next;
            end
        end

        ready_n = (state_n == S_IDLE);
    end

    assign char_ready_o = ready;
    assign wb_cyc_o     = cyc;
    assign wb_we_o      = cyc;
    assign wb_addr_o    = cyc ? waddr : 3'd0;
    assign wb_dat_o     = cyc ? wdat : 8'd0;
    assign col_o        = col;
    assign row_o        = row;
    assign err_o        = err;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Randomized bench for vga_term_ctrl: a Wishbone responder logs writes, a cursor model predicts them.
module tb_vga_term_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ch = 8'd0;
    logic       vld = 1'b0;
    logic       ready;
    logic       cyc;
    logic       we;
    logic [2:0] addr;
    logic [7:0] dat;
    logic       ack;
    logic [6:0] col;
    logic [4:0] row;
    logic       err;

    vga_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .ACK_TIMEOUT(15)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .char_i(ch), .char_valid_i(vld), .char_ready_o(ready),
        .wb_cyc_o(cyc), .wb_we_o(we), .wb_addr_o(addr), .wb_dat_o(dat), .wb_ack_i(ack),
        .col_o(col), .row_o(row), .err_o(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          ack_delay = 0;
    logic        hold_en = 1'b0;
    logic [2:0]  hold_addr = 3'd0;
    int          wait_cnt = 0;
    int          run = 0;
    int          last_run = 0;
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];

    int   m_col = 0;
    int   m_row = 0;
    logic m_err = 1'b0;

    assign ack = resp_ack | stray_ack;

    // Slave: acks ack_delay cycles after cyc rises, logs {addr,dat}, can withhold for one address.
    always @(negedge clk) begin
        if (!cyc) begin
            resp_ack = 1'b0;
            wait_cnt = 0;
            if (run != 0) begin
                last_run = run;
                run = 0;
            end
        end else begin
            run++;
            if (!resp_ack && !(hold_en && addr == hold_addr)) begin
                if (wait_cnt >= ack_delay) begin
                    resp_ack = 1'b1;
                    log_q.push_back({addr, dat});
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_linefeed();
        if (m_row < ROWS - 1) m_row++;
        else exp_q.push_back({3'd3, 8'h01});
    endtask

    task automatic apply_model(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({3'd1, 8'(m_col)});
            exp_q.push_back({3'd2, 8'(m_row)});
            exp_q.push_back({3'd0, b});
            if (m_col < COLS - 1) m_col++;
            else begin
                m_col = 0;
                model_linefeed();
            end
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) model_linefeed();
        else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            exp_q.push_back({3'd3, 8'h80});
            m_col = 0;
            m_row = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge where ready is seen again.
    task automatic send(input logic [7:0] b, input bit expect_timeout, output int lat);
        int n;
        log_q.delete();
        exp_q.delete();
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", 32'(ready), 32'd1);
        ch = b;
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        if (expect_timeout) begin
            exp_q.push_back({3'd1, 8'(m_col)});
            m_err = 1'b1;
        end else begin
            apply_model(b);
        end
        lat = 0;
        @(negedge clk);
        while (!ready && lat < 300) begin
            check("we_eq_cyc", 32'(we), 32'(cyc));
            lat++;
            @(negedge clk);
        end
        check($sformatf("ready_return_%02h", b), 32'(lat < 300), 32'd1);
        check($sformatf("nwrites_%02h", b), 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("write%0d_%02h", i, b), 32'(log_q[i]), 32'(exp_q[i]));
        check($sformatf("col_%02h", b), 32'(col), 32'(m_col));
        check($sformatf("row_%02h", b), 32'(row), 32'(m_row));
        check($sformatf("err_%02h", b), 32'(err), 32'(m_err));
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(126, 32));
    endfunction

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return rand_print();
        if (r < 14) return 8'h0D;
        if (r < 16) return 8'h0A;
        if (r < 18) return 8'h08;
        if (r < 19) return 8'h0C;
        return 8'($urandom_range(255, 127));
    endfunction

    initial begin
        int lat;
        int n;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dat", 32'(dat), 32'd0);
        check("rst_col", 32'(col), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(ready), 32'd1);

        ack_delay = 1;
        send(8'h41, 1'b0, lat);
        check("A_latency", 32'(lat), 32'd11);
        check("A_col", 32'(col), 32'd1);

        ack_delay = 0;
        send(8'h71, 1'b0, lat);
        check("q_latency", 32'(lat), 32'd8);

        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_ack_no_cyc", 32'(cyc), 32'd0);
        check("stray_ack_ready", 32'(ready), 32'd1);
        stray_ack = 1'b0;
        check("stray_ack_col", 32'(col), 32'd2);

        send(8'h0C, 1'b0, lat);
        while (m_row < 5) send(8'h0A, 1'b0, lat);
        while (m_col < 79) begin
            ack_delay = $urandom_range(0, 2);
            send(rand_print(), 1'b0, lat);
        end
        send(8'h5A, 1'b0, lat);
        check("Z_col", 32'(col), 32'd0);
        check("Z_row", 32'(row), 32'd6);
        check("Z_nwrites", 32'(log_q.size()), 32'd3);

        while (m_row < 29) send(8'h0A, 1'b0, lat);
        send(8'h0A, 1'b0, lat);
        check("LF29_row", 32'(row), 32'd29);
        check("LF29_nwrites", 32'(log_q.size()), 32'd1);

        while (m_col < 79) send(rand_print(), 1'b0, lat);
        send(8'h78, 1'b0, lat);
        check("x_nwrites", 32'(log_q.size()), 32'd4);
        check("x_col", 32'(col), 32'd0);
        check("x_row", 32'(row), 32'd29);

        send(8'h0D, 1'b0, lat);
        check("CR_nwrites", 32'(log_q.size()), 32'd0);
        send(8'h08, 1'b0, lat);
        check("BS0_col", 32'(col), 32'd0);
        send(8'h0C, 1'b0, lat);
        check("FF_row", 32'(row), 32'd0);

        for (int i = 0; i < 150; i++) begin
            ack_delay = $urandom_range(0, 3);
            send(rand_byte(), 1'b0, lat);
        end

        ack_delay = 0;
        hold_en = 1'b1;
        hold_addr = 3'd2;
        send(8'h54, 1'b1, lat);
        @(negedge clk);
        check("timeout_cyc_cycles", 32'(last_run), 32'd15);
        hold_en = 1'b0;
        send(8'h55, 1'b0, lat);

        check("err_sticky", 32'(err), 32'd1);
        hold_en = 1'b1;
        hold_addr = 3'd1;
        ch = 8'h42;
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cyc && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("cyc_before_reset", 32'(cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cyc", 32'(cyc), 32'd0);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_dat", 32'(dat), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_col", 32'(col), 32'd0);
        check("midrst_row", 32'(row), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_en = 1'b0;
        m_col = 0;
        m_row = 0;
        m_err = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 32'(ready), 32'd1);
        send(8'h43, 1'b0, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
